// File: rtl/sa_chan_rx.sv
// Receiving end of the self-timed Send/Ack channel: synchronises the active-low
// Send strobe, captures words into a small FIFO and offers them on valid/ready.
module sa_chan_rx #(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     MR,
  input  logic                     Send_in,
  input  logic [DW-1:0]            Data_in,
  output logic                     Ack_out,
  output logic [DW-1:0]            dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {INIT, RDY, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic [SYNC_STAGES:0]   prime_p0;
  logic                   s_sync, s_prev, primed, fall;
  logic                   wr, pop, viol;
  logic [AW-1:0]          wr_ptr, rd_ptr, rd_inc;
  logic [DW-1:0]          mem [DEPTH];

  // Synchroniser stage
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      sync_p0  <= '1;
      s_prev   <= 1'b1;
      prime_p0 <= '0;
    end else begin
      sync_p0  <= {sync_p0[SYNC_STAGES-2:0], Send_in};
      s_prev   <= s_sync;
      prime_p0 <= {prime_p0[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign s_sync = sync_p0[SYNC_STAGES-1];
  // Edges are ignored until the chain holds only real samples, so a Send held
  // low through reset is not mistaken for a new request.
  assign primed = prime_p0[SYNC_STAGES];
  assign fall   = primed & s_prev & ~s_sync;

  assign dout_valid = (count != '0);
  assign pop        = dout_valid & dout_ready;
  assign rd_inc     = rd_ptr + 1'b1;

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    viol      = 1'b0;
    case (state)
      INIT: begin
        viol = fall;
        if (!fall) state_nxt = RDY;
      end
      RDY: begin
        if (fall) begin
          wr        = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        viol = fall;
        if (s_sync && ((count < CW'(DEPTH)) || pop)) state_nxt = RDY;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Control stage
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      state     <= INIT;
      Ack_out   <= 1'b0;
      proto_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
    end else begin
      state     <= state_nxt;
      Ack_out   <= (state_nxt == RDY);
      proto_err <= proto_err | viol;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_inc;
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr && ((count == '0) || ((count == CW'(1)) && pop)))
        dout <= Data_in;
      else if (pop && (count > CW'(1)))
        dout <= mem[rd_inc];
    end
  end

  // Storage stage
  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= Data_in;
  end

endmodule

// File: tb/tb_sa_chan_rx.sv
// Bench for sa_chan_rx: vector table for sender transfers, scoreboard on pops,
// hand-written sequences for reset, violation and full-FIFO corners.
module tb_sa_chan_rx;

  logic       CLK = 1'b0;
  logic       MR = 1'b1;
  logic       Send_in = 1'b1;
  logic [7:0] Data_in = 8'h00;
  logic       Ack_out;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [2:0] count;
  logic       proto_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] last_pop = 8'h00;
  logic       track = 1'b0;
  int         maxcnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       ready;
    int         exp_count;
    logic       exp_ack;
  } vec_t;
  vec_t vecs[12];

  sa_chan_rx #(.DW(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .MR(MR), .Send_in(Send_in), .Data_in(Data_in),
    .Ack_out(Ack_out), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .count(count), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_ack(input logic v, input string nm);
    int n = 0;
    while (Ack_out !== v && n < 40) begin
      cyc(1);
      n++;
    end
    chk(nm, 32'(Ack_out), 32'(v));
  endtask

  task automatic send_word(input logic [7:0] d, input logic push);
    wait_ack(1'b1, "send_wait_ack1");
    Data_in = d;
    Send_in = 1'b0;
    if (push) q.push_back(d);
    wait_ack(1'b0, "send_wait_ack0");
    Send_in = 1'b1;
  endtask

  // Scoreboard: every accepted word must match the oldest expected word
  always @(negedge CLK) begin
    if (track && int'(count) > maxcnt) maxcnt = int'(count);
    if (dout_valid && dout_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", dout);
      end else begin
        last_pop = q.pop_front();
        if (dout !== last_pop) begin
          errors++;
          $display("FAIL pop_data actual=%0h required=%0h", dout, last_pop);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = '{8'(i + 1), 1'b1, 0, 1'b1};
    vecs[8]  = '{8'h11, 1'b0, 1, 1'b1};
    vecs[9]  = '{8'h22, 1'b0, 2, 1'b1};
    vecs[10] = '{8'h33, 1'b0, 3, 1'b1};
    vecs[11] = '{8'h44, 1'b0, 4, 1'b0};

    // Reset behaviour
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("rst_ack", 32'(Ack_out), 0);
    end
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_err", 32'(proto_err), 0);
    chk("rst_dout", 32'(dout), 0);
    MR = 1'b0;
    cyc(1);
    chk("rel_ack", 32'(Ack_out), 1);
    cyc(4);

    // Single transfer with exact latency
    Data_in = 8'hA5;
    Send_in = 1'b0;
    q.push_back(8'hA5);
    cyc(1);
    cyc(1);
    chk("e1_ack", 32'(Ack_out), 1);
    cyc(1);
    chk("e2_ack", 32'(Ack_out), 0);
    chk("e2_valid", 32'(dout_valid), 1);
    chk("e2_dout", 32'(dout), 32'h A5);
    chk("e2_count", 32'(count), 1);
    Send_in = 1'b1;
    wait_ack(1'b1, "single_ack_back");
    dout_ready = 1'b1;
    cyc(1);
    dout_ready = 1'b0;
    chk("single_count0", 32'(count), 0);
    chk("single_lastpop", 32'(last_pop), 32'hA5);

    // Streaming then filling, from the vector table
    track = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        track = 1'b0;
        chk("stream_maxcnt_le1", 32'(maxcnt > 1), 0);
        chk("stream_err", 32'(proto_err), 0);
        chk("stream_lastpop", 32'(last_pop), 32'h08);
      end
      dout_ready = vecs[i].ready;
      send_word(vecs[i].data, 1'b1);
      cyc(6);
      chk("vec_count", 32'(count), 32'(vecs[i].exp_count));
      chk("vec_ack", 32'(Ack_out), 32'(vecs[i].exp_ack));
    end
    chk("full_dout", 32'(dout), 32'h11);

    // Protocol violation while full and busy
    Data_in = 8'hEE;
    Send_in = 1'b0;
    cyc(5);
    Send_in = 1'b1;
    cyc(4);
    chk("viol_err", 32'(proto_err), 1);
    chk("viol_count", 32'(count), 4);
    chk("viol_ack", 32'(Ack_out), 0);

    // Single-cycle pop from a full FIFO reopens the channel
    dout_ready = 1'b1;
    cyc(1);
    dout_ready = 1'b0;
    chk("pulse_dout", 32'(dout), 32'h22);
    chk("pulse_count", 32'(count), 3);
    cyc(1);
    chk("pulse_ack", 32'(Ack_out), 1);

    // Drain: 0xEE must never surface
    dout_ready = 1'b1;
    cyc(6);
    dout_ready = 1'b0;
    chk("drain_count", 32'(count), 0);
    chk("drain_q_empty", 32'(q.size()), 0);
    chk("drain_err_sticky", 32'(proto_err), 1);

    // Reset mid-operation with Send held low
    send_word(8'h61, 1'b1);
    send_word(8'h62, 1'b1);
    send_word(8'h63, 1'b1);
    cyc(6);
    chk("pre_mr_count", 32'(count), 3);
    Data_in = 8'h77;
    Send_in = 1'b0;
    #1 MR = 1'b1;
    #1;
    chk("mr_count", 32'(count), 0);
    chk("mr_valid", 32'(dout_valid), 0);
    chk("mr_ack", 32'(Ack_out), 0);
    q.delete();
    cyc(3);
    MR = 1'b0;
    cyc(10);
    chk("held_low_count", 32'(count), 0);
    chk("held_low_valid", 32'(dout_valid), 0);
    chk("held_low_ack", 32'(Ack_out), 1);
    chk("mr_err_clear", 32'(proto_err), 0);
    Send_in = 1'b1;
    cyc(4);
    send_word(8'h5A, 1'b1);
    dout_ready = 1'b1;
    cyc(6);
    dout_ready = 1'b0;
    chk("post_mr_count", 32'(count), 0);
    chk("post_mr_lastpop", 32'(last_pop), 32'h5A);
    chk("post_mr_q_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
